io_port_ctrl: RTL and testbench
===============================

// Module: io_port_ctrl
// PURPOSE
//  Sits between the CPU I/O instructions (INP/OUT/SKI/SKO/SIO/PIO/IMK) and two device channels:
//  parallel (P) and serial/UART (S). Holds per-channel FGI/FGO flags and INPR buffers, routes them
//  to the CPU through a port select, sequences UART transmits, and raises the masked interrupt request.
// PARAMETERS
//  RST_SEL     1'b0     port select after reset (0 = parallel, 1 = serial)
//  TX_TIMEOUT  16'd4095 cycles tx_rdy may stay low before a serial transmit is abandoned
// PORTS
//  clk        in   1  system clock; all state updates on posedge
//  rst        in   1  synchronous, active-high reset
//  inp_req    in   1  CPU INP: consume INPR of the selected channel
//  out_req    in   1  CPU OUT: send out_data on the selected channel
//  out_data   in   8  AC[7:0] for OUT
//  sio_req    in   1  select serial channel
//  pio_req    in   1  select parallel channel
//  imk_req    in   1  load interrupt mask from imk_data
//  imk_data   in   4  mask {S_in, S_out, P_in, P_out}
//  fgi        out  1  FGI of the selected channel (SKI)
//  fgo        out  1  FGO of the selected channel (SKO)
//  inpr       out  8  INPR of the selected channel
//  intr_req   out  1  registered, masked OR of all four flags
//  pin_stb    in   1  parallel-in data valid (1 cycle)
//  pin_data   in   8  parallel-in byte
//  pout_data  out  8  parallel-out byte (held)
//  pout_ack   in   1  parallel-out device consumed byte (1 cycle)
//  rx_data    in   8  UART receiver byte
//  rx_rdy     in   1  UART receiver ready (level)
//  rx_error   in   1  UART framing error, qualifies rx_rdy
//  tx_byte    out  8  UART transmit byte
//  tx_start   out  1  UART transmit start (1-cycle pulse)
//  tx_rdy     in   1  UART transmitter idle
//  ovr        out  4  sticky overrun flags {S_in, S_out, P_in, P_out}
//  ovr_clr    in   1  clear ovr
// BEHAVIOUR
//  Reset: sel = RST_SEL, imsk = 0, fgi_p = fgi_s = 0, fgo_p = fgo_s = 1, inpr_p = inpr_s = 0,
//    pout_data = 0, tx_byte = 0, tx_start = 0, intr_req = 0, ovr = 0, tx FSM = IDLE, rx edge reg = 0.
//    Reset mid-transmit aborts the FSM; no tx_start is issued afterwards.
//  sio_req sets sel = 1; pio_req sets sel = 0; both in the same cycle: no change. imk_req loads imsk.
//  fgi, fgo and inpr are combinational muxes of the selected channel. Flags are updated at the next edge.
//  P-in: pin_stb with pre-edge fgi_p = 0 -> inpr_p <= pin_data, fgi_p <= 1. With fgi_p = 1 -> byte dropped, ovr[1] <= 1.
//  S-in: rx_rdy rising edge (registered prev) with !rx_error, same rule into inpr_s/fgi_s/ovr[3].
//    With rx_error the byte is dropped and no flag changes.
//  inp_req clears the selected fgi. A strobe on the same channel in the same cycle is judged against the
//    pre-edge flag: if the flag was 1 it is an overrun and the flag ends 0. If the flag was 0 the strobe wins and the flag ends 1.
//  OUT with selected fgo = 1: fgo <= 0. P: pout_data <= out_data; pout_ack then sets fgo_p.
//    S: tx_byte <= out_data and the FSM starts. OUT with fgo = 0: ignored, ovr[0]/ovr[2] <= 1.
//  pout_ack while fgo_p = 1: ignored.
//  Tx FSM:
//    IDLE -(OUT on S)-> LOAD.
//    LOAD: waits for tx_rdy = 1, pulses tx_start for 1 cycle -> BUSY.
//    BUSY: waits for tx_rdy = 0 -> DRAIN.
//    DRAIN: waits for tx_rdy = 1 -> IDLE, fgo_s <= 1.
//    A 16-bit counter runs in BUSY and DRAIN. When it reaches TX_TIMEOUT: -> IDLE, fgo_s <= 1, ovr[2] <= 1.
//  A select change while a transfer is pending does not affect it; the flags are per-channel.
//  intr_req <= |({fgi_s, fgo_s, fgi_p, fgo_p} & imsk): one cycle after any flag or mask change.
//  ovr_clr clears ovr. A concurrent set wins.
// CONFIGURATION
//  IO_PORT_CTRL_TRACE_EN defined: $display with $stime and channel on every flag set/clear, overrun and tx timeout.
//  Not defined: no simulation output; RTL behaviour is identical.
// STRUCTURE
//  Shared constants go into the common def header: channel bit indices (CH_P_OUT = 0, CH_P_IN = 1,
//    CH_S_OUT = 2, CH_S_IN = 3) and the tx state encodings.
//  Sub-module io_tx_seq: the tx FSM plus its timeout counter.
//    Inputs: clk, rst, go, tx_rdy. Outputs: tx_start, done, timeout.
// TESTING
//  1. Reset, sel = P: pin_stb with 8'hA5 -> fgi = 1, inpr = A5. inp_req -> fgi = 0 next cycle.
//  2. sio_req, out_req with 8'h41 -> fgo = 0, tx_byte = 41, a single tx_start once tx_rdy = 1.
//     tx_rdy low 10 cycles then high -> fgo = 1.
//  3. imk_data = 4'b1000: serial rx_rdy rising edge with 8'h0D -> fgi_s = 1, intr_req = 1 one cycle later.
//     imk_data = 0 -> intr_req drops.
//  4. P-in: second pin_stb (8'h22) before INP -> inpr stays at the first byte, ovr[1] = 1.
//     ovr_clr -> ovr = 0.
//  5. Serial tx with tx_rdy held low for TX_TIMEOUT + 1 cycles -> back to IDLE, fgo_s = 1, ovr[2] = 1.
//  6. inp_req and pin_stb in the same cycle with fgi_p = 1 -> fgi_p = 0, ovr[1] = 1.
//     rst asserted during BUSY -> no further tx_start, fgo_s = 1.

Source files
------------

// File: rtl/io_port_ctrl_pkg.sv
// Shared constants for the CPU I/O port controller: channel flag bit positions and tx sequencer states.
package io_port_ctrl_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned NCH    = 4;
    localparam int unsigned TMO_W  = 16;

    // Bit positions inside {S_in, S_out, P_in, P_out} vectors (imsk, ovr, flags)
    localparam int unsigned CH_P_OUT = 0;
    localparam int unsigned CH_P_IN  = 1;
    localparam int unsigned CH_S_OUT = 2;
    localparam int unsigned CH_S_IN  = 3;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_LOAD  = 2'd1,
        TX_BUSY  = 2'd2,
        TX_DRAIN = 2'd3
    } tx_state_e;

endpackage

// File: rtl/io_tx_seq.sv
// UART transmit sequencer: waits for an idle transmitter, issues one tx_start pulse,
// then tracks busy/idle of tx_rdy with an abandon timeout.
module io_tx_seq
    import io_port_ctrl_pkg::*;
#(
    parameter logic [TMO_W-1:0] TX_TIMEOUT = 16'd4095
) (
    input  logic clk,
    input  logic rst,
    input  logic go,
    input  logic tx_rdy,
    output logic tx_start,
    output logic done,
    output logic timeout
);

    tx_state_e        state;
    tx_state_e        state_nxt;
    logic             tx_start_nxt;
    logic [TMO_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= TX_IDLE;
            tx_start <= 1'b0;
            cnt      <= '0;
        end else begin
            state    <= state_nxt;
            tx_start <= tx_start_nxt;
            // Counter is zero on entry to BUSY because IDLE/LOAD always precede it
            cnt      <= (state == TX_BUSY || state == TX_DRAIN) ? cnt + TMO_W'(1) : '0;
        end
    end

    always_comb begin
        state_nxt    = state;
        tx_start_nxt = 1'b0;
        done         = 1'b0;
        timeout      = 1'b0;
        case (state)
            TX_IDLE: begin
                if (go) state_nxt = TX_LOAD;
            end
            TX_LOAD: begin
                if (tx_rdy) begin
                    state_nxt    = TX_BUSY;
                    tx_start_nxt = 1'b1;
                end
            end
            TX_BUSY: begin
                if (cnt == TX_TIMEOUT) begin
                    state_nxt = TX_IDLE;
                    timeout   = 1'b1;
                end else if (!tx_rdy) begin
                    state_nxt = TX_DRAIN;
                end
            end
            TX_DRAIN: begin
                // A completion on the last allowed cycle is still a completion
                if (tx_rdy) begin
                    state_nxt = TX_IDLE;
                    done      = 1'b1;
                end else if (cnt == TX_TIMEOUT) begin
                    state_nxt = TX_IDLE;
                    timeout   = 1'b1;
                end
            end
            default: state_nxt = TX_IDLE;
        endcase
    end

endmodule

// File: rtl/io_port_ctrl.sv
// CPU I/O port controller for a parallel and a serial channel: FGI/FGO flags, INPR buffers,
// overrun tracking and masked interrupt. Optional trace output with IO_PORT_CTRL_TRACE_EN.
module io_port_ctrl
    import io_port_ctrl_pkg::*;
#(
    parameter logic             RST_SEL    = 1'b0,
    parameter logic [TMO_W-1:0] TX_TIMEOUT = 16'd4095
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inp_req,
    input  logic              out_req,
    input  logic [DATA_W-1:0] out_data,
    input  logic              sio_req,
    input  logic              pio_req,
    input  logic              imk_req,
    input  logic [NCH-1:0]    imk_data,
    output logic              fgi,
    output logic              fgo,
    output logic [DATA_W-1:0] inpr,
    output logic              intr_req,
    input  logic              pin_stb,
    input  logic [DATA_W-1:0] pin_data,
    output logic [DATA_W-1:0] pout_data,
    input  logic              pout_ack,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_rdy,
    input  logic              rx_error,
    output logic [DATA_W-1:0] tx_byte,
    output logic              tx_start,
    input  logic              tx_rdy,
    output logic [NCH-1:0]    ovr,
    input  logic              ovr_clr
);

    logic              sel;
    logic [NCH-1:0]    imsk;
    logic              fgi_p, fgi_s, fgo_p, fgo_s;
    logic [DATA_W-1:0] inpr_p, inpr_s;
    logic              rx_prev;
    logic              inp_p, inp_s, out_p, out_s, s_stb;
    logic              tx_go, tx_done, tx_timeout;
    logic [NCH-1:0]    ovr_set;
    logic [NCH-1:0]    flags;

    assign flags = {fgi_s, fgo_s, fgi_p, fgo_p};

    assign fgi  = sel ? fgi_s  : fgi_p;
    assign fgo  = sel ? fgo_s  : fgo_p;
    assign inpr = sel ? inpr_s : inpr_p;

    // Request decode and overrun detection, all judged against pre-edge flags
    always_comb begin
        inp_p   = inp_req && !sel;
        inp_s   = inp_req && sel;
        out_p   = out_req && !sel;
        out_s   = out_req && sel;
        s_stb   = rx_rdy && !rx_prev && !rx_error;
        tx_go   = out_s && fgo_s;
        ovr_set = '0;
        ovr_set[CH_P_OUT] = out_p && !fgo_p;
        ovr_set[CH_P_IN]  = pin_stb && fgi_p;
        ovr_set[CH_S_OUT] = (out_s && !fgo_s) || tx_timeout;
        ovr_set[CH_S_IN]  = s_stb && fgi_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel       <= RST_SEL;
            imsk      <= '0;
            fgi_p     <= 1'b0;
            fgi_s     <= 1'b0;
            fgo_p     <= 1'b1;
            fgo_s     <= 1'b1;
            inpr_p    <= '0;
            inpr_s    <= '0;
            pout_data <= '0;
            tx_byte   <= '0;
            intr_req  <= 1'b0;
            ovr       <= '0;
            rx_prev   <= 1'b0;
        end else begin
            if (sio_req && !pio_req) begin
                sel <= 1'b1;
            end else if (pio_req && !sio_req) begin
                sel <= 1'b0;
            end
            if (imk_req) imsk <= imk_data;
            rx_prev <= rx_rdy;

            // A strobe into an empty buffer beats a concurrent INP
            if (pin_stb && !fgi_p) begin
                inpr_p <= pin_data;
                fgi_p  <= 1'b1;
            end else if (inp_p) begin
                fgi_p  <= 1'b0;
            end
            if (s_stb && !fgi_s) begin
                inpr_s <= rx_data;
                fgi_s  <= 1'b1;
            end else if (inp_s) begin
                fgi_s  <= 1'b0;
            end

            if (out_p && fgo_p) begin
                fgo_p     <= 1'b0;
                pout_data <= out_data;
            end else if (pout_ack && !fgo_p) begin
                fgo_p     <= 1'b1;
            end
            if (tx_go) begin
                fgo_s   <= 1'b0;
                tx_byte <= out_data;
            end else if (tx_done || tx_timeout) begin
                fgo_s   <= 1'b1;
            end

            intr_req <= |(flags & imsk);
            ovr      <= (ovr_clr ? '0 : ovr) | ovr_set;
        end
    end

    io_tx_seq #(
        .TX_TIMEOUT (TX_TIMEOUT)
    ) u_tx_seq (
        .clk      (clk),
        .rst      (rst),
        .go       (tx_go),
        .tx_rdy   (tx_rdy),
        .tx_start (tx_start),
        .done     (tx_done),
        .timeout  (tx_timeout)
    );

`ifdef IO_PORT_CTRL_TRACE_EN
    logic [NCH-1:0] trc_flags;

    always @(posedge clk) begin
        trc_flags <= flags;
        for (int i = 0; i < NCH; i++) begin
            if (!rst && flags[i] != trc_flags[i])
                $display("%0d io_port_ctrl: flag ch%0d %s", $stime, i, flags[i] ? "set" : "clear");
            if (!rst && ovr_set[i])
                $display("%0d io_port_ctrl: overrun ch%0d", $stime, i);
        end
        if (!rst && tx_timeout)
            $display("%0d io_port_ctrl: tx timeout ch%0d", $stime, CH_S_OUT);
    end
`else
`endif

endmodule

// File: tb/tb_io_port_ctrl.sv
// Self-checking bench for io_port_ctrl: directed scenarios plus randomized traffic,
// every cycle compared against a per-channel behavioural model.
module tb_io_port_ctrl;

    localparam int T = 4095;

    logic       clk, rst;
    logic       inp_req, out_req, sio_req, pio_req, imk_req;
    logic [7:0] out_data;
    logic [3:0] imk_data;
    logic       fgi, fgo, intr_req;
    logic [7:0] inpr;
    logic       pin_stb, pout_ack;
    logic [7:0] pin_data, pout_data;
    logic [7:0] rx_data;
    logic       rx_rdy, rx_error;
    logic [7:0] tx_byte;
    logic       tx_start, tx_rdy;
    logic [3:0] ovr;
    logic       ovr_clr;

    io_port_ctrl dut (
        .clk(clk), .rst(rst), .inp_req(inp_req), .out_req(out_req), .out_data(out_data),
        .sio_req(sio_req), .pio_req(pio_req), .imk_req(imk_req), .imk_data(imk_data),
        .fgi(fgi), .fgo(fgo), .inpr(inpr), .intr_req(intr_req),
        .pin_stb(pin_stb), .pin_data(pin_data), .pout_data(pout_data), .pout_ack(pout_ack),
        .rx_data(rx_data), .rx_rdy(rx_rdy), .rx_error(rx_error),
        .tx_byte(tx_byte), .tx_start(tx_start), .tx_rdy(tx_rdy),
        .ovr(ovr), .ovr_clr(ovr_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    int n_starts = 0;

    // Reference model: index 0 = parallel, 1 = serial
    bit       m_sel;
    bit [3:0] m_imsk;
    bit       m_fgi[2];
    bit       m_fgo[2];
    bit [7:0] m_inpr[2];
    bit [7:0] m_pout, m_txb;
    bit       m_txs, m_intr, m_rx_prev;
    bit [3:0] m_ovr;
    bit       m_tx_wait, m_tx_act, m_tx_low;
    int       m_tx_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit       n_fgi[2];
        bit       n_fgo[2];
        bit [3:0] oset;
        bit       stb[2];
        bit [7:0] din[2];
        bit       fin, tmo, here;
        if (rst) begin
            m_sel = 1'b0; m_imsk = '0; m_pout = '0; m_txb = '0; m_txs = 0; m_intr = 0;
            m_ovr = '0; m_rx_prev = 0; m_tx_wait = 0; m_tx_act = 0; m_tx_low = 0; m_tx_cnt = 0;
            for (int c = 0; c < 2; c++) begin
                m_fgi[c] = 0; m_fgo[c] = 1; m_inpr[c] = '0;
            end
            return;
        end
        n_fgi = m_fgi;
        n_fgo = m_fgo;
        oset  = '0;
        stb[0] = pin_stb;
        stb[1] = rx_rdy && !m_rx_prev && !rx_error;
        din[0] = pin_data;
        din[1] = rx_data;
        fin = 0; tmo = 0; m_txs = 0;
        // transmitter: wait for idle UART, start, see it go busy then idle, or give up
        if (m_tx_wait) begin
            if (tx_rdy) begin
                m_tx_wait = 0; m_tx_act = 1; m_tx_low = 0; m_tx_cnt = 0; m_txs = 1;
            end
        end else if (m_tx_act) begin
            if (m_tx_low && tx_rdy) fin = 1;
            else if (m_tx_cnt == T) tmo = 1;
            else begin
                if (!tx_rdy) m_tx_low = 1;
                m_tx_cnt++;
            end
            if (fin || tmo) m_tx_act = 0;
        end
        for (int c = 0; c < 2; c++) begin
            here = inp_req && (int'(m_sel) == c);
            if (stb[c] && !m_fgi[c]) begin
                m_inpr[c] = din[c];
                n_fgi[c]  = 1;
            end else begin
                if (stb[c]) oset[2*c+1] = 1;
                if (here) n_fgi[c] = 0;
            end
            here = out_req && (int'(m_sel) == c);
            if (here && m_fgo[c]) begin
                n_fgo[c] = 0;
                if (c == 0) m_pout = out_data;
                else begin
                    m_txb = out_data;
                    m_tx_wait = 1;
                end
            end else if (here) begin
                oset[2*c] = 1;
            end
        end
        if (pout_ack && !m_fgo[0]) n_fgo[0] = 1;
        if (fin || tmo) n_fgo[1] = 1;
        if (tmo) oset[2] = 1;
        m_intr = |({m_fgi[1], m_fgo[1], m_fgi[0], m_fgo[0]} & m_imsk);
        if (imk_req) m_imsk = imk_data;
        if (sio_req && !pio_req) m_sel = 1;
        if (pio_req && !sio_req) m_sel = 0;
        m_ovr = (ovr_clr ? 4'b0 : m_ovr) | oset;
        m_rx_prev = rx_rdy;
        m_fgi = n_fgi;
        m_fgo = n_fgo;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("fgi",      fgi,       m_fgi[m_sel]);
        check("fgo",      fgo,       m_fgo[m_sel]);
        check("inpr",     inpr,      m_inpr[m_sel]);
        check("intr_req", intr_req,  m_intr);
        check("pout",     pout_data, m_pout);
        check("tx_byte",  tx_byte,   m_txb);
        check("tx_start", tx_start,  m_txs);
        check("ovr",      ovr,       m_ovr);
        if (tx_start === 1'b1) n_starts++;
    endtask

    task automatic clr_req();
        inp_req = 0; out_req = 0; sio_req = 0; pio_req = 0; imk_req = 0;
        pin_stb = 0; pout_ack = 0; ovr_clr = 0;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int s0, n;
        clr_req();
        out_data = '0; imk_data = '0; pin_data = '0; rx_data = '0;
        rx_rdy = 0; rx_error = 0; tx_rdy = 1; rst = 1;
        cycle(); cycle();
        check("rst_fgi", fgi, 0);
        check("rst_fgo", fgo, 1);
        check("rst_inpr", inpr, 0);
        check("rst_ovr", ovr, 0);
        check("rst_intr", intr_req, 0);
        rst = 0;

        // parallel input and INP
        pin_data = 8'hA5; pin_stb = 1; cycle(); clr_req();
        check("t1_fgi", fgi, 1);
        check("t1_inpr", inpr, 8'hA5);
        inp_req = 1; cycle(); clr_req();
        check("t1_fgi_clr", fgi, 0);

        // serial transmit with normal busy/idle handshake
        s0 = n_starts;
        sio_req = 1; cycle(); clr_req();
        out_data = 8'h41; out_req = 1; cycle(); clr_req();
        check("t2_fgo", fgo, 0);
        check("t2_txb", tx_byte, 8'h41);
        repeat (3) cycle();
        tx_rdy = 0;
        repeat (10) cycle();
        tx_rdy = 1;
        for (int i = 0; i < 20 && fgo !== 1'b1; i++) cycle();
        check("t2_fgo_done", fgo, 1);
        check("t2_starts", n_starts - s0, 1);

        // masked serial-in interrupt
        imk_data = 4'b1000; imk_req = 1; cycle(); clr_req();
        rx_data = 8'h0D; rx_rdy = 1; cycle();
        check("t3_fgi", fgi, 1);
        check("t3_intr_lag", intr_req, 0);
        cycle();
        check("t3_intr", intr_req, 1);
        check("t3_inpr", inpr, 8'h0D);
        imk_data = 4'b0000; imk_req = 1; cycle(); clr_req();
        cycle();
        check("t3_intr_off", intr_req, 0);
        rx_rdy = 0; inp_req = 1; cycle(); clr_req();

        // parallel-in overrun and clear
        pio_req = 1; cycle(); clr_req();
        pin_data = 8'h11; pin_stb = 1; cycle();
        pin_data = 8'h22; cycle(); clr_req();
        check("t4_inpr", inpr, 8'h11);
        check("t4_ovr", ovr, 4'b0010);
        ovr_clr = 1; cycle(); clr_req();
        check("t4_ovr_clr", ovr, 0);

        // INP racing a strobe into a full buffer
        inp_req = 1; pin_stb = 1; pin_data = 8'h33; cycle(); clr_req();
        check("t6_fgi", fgi, 0);
        check("t6_ovr", ovr, 4'b0010);
        check("t6_inpr", inpr, 8'h11);

        // serial transmit abandoned after the timeout
        sio_req = 1; cycle(); clr_req();
        out_data = 8'h5A; out_req = 1; cycle(); clr_req();
        cycle();
        check("t5_start", tx_start, 1);
        tx_rdy = 0;
        n = 0;
        while (fgo !== 1'b1 && n < 5000) begin
            cycle();
            n++;
        end
        check("t5_cycles", n, T + 1);
        check("t5_ovr_s", ovr[2], 1);

        // reset while the transmitter is busy
        tx_rdy = 1; out_data = 8'h77; out_req = 1; cycle(); clr_req();
        cycle(); cycle(); cycle();
        rst = 1; cycle(); rst = 0;
        s0 = n_starts;
        sio_req = 1; cycle(); clr_req();
        check("t6_rst_fgo", fgo, 1);
        for (int i = 0; i < 20; i++) begin
            if (i % 3 == 0) tx_rdy = !tx_rdy;
            cycle();
        end
        check("t6_rst_starts", n_starts - s0, 0);

        // randomized traffic
        tx_rdy = 1;
        for (int k = 0; k < 3000; k++) begin
            inp_req  = ($urandom_range(0, 99) < 15);
            out_req  = ($urandom_range(0, 99) < 15);
            sio_req  = ($urandom_range(0, 99) < 10);
            pio_req  = ($urandom_range(0, 99) < 10);
            imk_req  = ($urandom_range(0, 99) < 5);
            pin_stb  = ($urandom_range(0, 99) < 15);
            pout_ack = ($urandom_range(0, 99) < 15);
            ovr_clr  = ($urandom_range(0, 99) < 5);
            rx_error = ($urandom_range(0, 99) < 20);
            if ($urandom_range(0, 99) < 25) rx_rdy = !rx_rdy;
            if ($urandom_range(0, 99) < 20) tx_rdy = !tx_rdy;
            out_data = 8'($urandom);
            pin_data = 8'($urandom);
            rx_data  = 8'($urandom);
            imk_data = 4'($urandom);
            rst      = ($urandom_range(0, 999) < 3);
            cycle();
        end
        rst = 0;
        clr_req();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
